// File: rtl/alu_pkg.sv
//-----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: operation encodings, controller
// state encoding and the bit positions of the {N, Z, C, V} flag nibble.
// No ports; imported by alu_seq and its testbench.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

package alu_pkg;

  // Operation select as seen on the op input.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SMAG = 3'b110,
    OP_RSVD = 3'b111
  } aluOp_e;

  // Controller states: waiting for work, iterating a multiply, holding a result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } aluState_e;

  // Bit positions inside the 4-bit flags output.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
//-----------------------------------------------------------------------------
// alu_mul_seq
// Unsigned shift-add multiplier, one multiplier bit per clock.
// The bit-0 partial product is folded into the start cycle, so the full
// product is ready WIDTH cycles after start (done is a level that stays
// high for exactly one cycle while product holds the final value).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start            load a/b and begin (only pulsed while idle)
//   a, b             unsigned multiplicand / multiplier
//   done             product valid this cycle
//   product          2*WIDTH-bit accumulated product
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // Next-state for the iteration. On start the first multiplier bit is
  // consumed immediately, leaving WIDTH-1 shift-add steps; the counter then
  // reaches zero exactly when the last bit has been added in, which is the
  // single cycle where done is raised before busy drops.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = b >> 1;
      cnt_d    = CW'(WIDTH-1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // Iteration registers; reset clears the accumulator and counter so an
  // aborted multiply leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
//-----------------------------------------------------------------------------
// alu_seq
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// (ADD, SUB, AND, OR, XOR, SMAG, reserved) are evaluated at accept time and
// registered; MUL runs through alu_mul_seq. The result stays held in DONE
// until the consumer takes it.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake (ready only when idle)
//   op, a, b              operation select and operands
//   out_valid / out_ready result handshake (valid only in DONE)
//   result                registered WIDTH-bit result
//   flags                 registered {N, Z, C, V}
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  aluState_e          state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               accept, mulStart, mulDone;
  logic [2*WIDTH-1:0] mulProduct;
  logic [WIDTH-1:0]   aluRes;
  logic [3:0]         aluFlags;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-2:0]   negLow;
  logic               aluC, aluV;

  assign accept   = in_valid && in_ready;
  assign mulStart = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) uMul (
    .clk     (clk),
    .reset   (reset),
    .start   (mulStart),
    .a       (a),
    .b       (b),
    .done    (mulDone),
    .product (mulProduct)
  );

  // State register; asynchronous reset drops any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a multiply detours through ST_MUL until the multiplier
  // reports done; everything else goes straight to ST_DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (op == OP_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (mulDone) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so they are glitch-free with
  // respect to the request inputs.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Single-cycle datapath. SUB is done as a + ~b + 1 so that the carry out
  // reads as "no borrow". SMAG only needs the low WIDTH-1 bits of -a, and
  // for the most negative input those bits are zero, giving {1, 0...0}.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    negLow = ~a[WIDTH-2:0] + 1'b1;
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (aluOp_e'(op))
      OP_ADD: begin
        aluRes = sum[WIDTH-1:0];
        aluC   = sum[WIDTH];
        aluV   = (a[WIDTH-1] == b[WIDTH-1]) && (aluRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = diff[WIDTH-1:0];
        aluC   = diff[WIDTH];
        aluV   = (a[WIDTH-1] != b[WIDTH-1]) && (aluRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  aluRes = a & b;
      OP_OR:   aluRes = a | b;
      OP_XOR:  aluRes = a ^ b;
      OP_SMAG: begin
        aluRes = a[WIDTH-1] ? {1'b1, negLow} : a;
        aluV   = (a == MOST_NEG);
      end
      default: aluRes = '0;
    endcase
    aluFlags         = '0;
    aluFlags[FLAG_N] = aluRes[WIDTH-1];
    aluFlags[FLAG_Z] = (aluRes == '0);
    aluFlags[FLAG_C] = aluC;
    aluFlags[FLAG_V] = aluV;
  end

  // Result/flag load: single-cycle ops load on accept, MUL loads when the
  // multiplier finishes; otherwise the registers hold so DONE stays stable.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    if (accept && !mulStart) begin
      result_d = aluRes;
      flags_d  = aluFlags;
    end else if ((state_q == ST_MUL) && mulDone) begin
      result_d         = mulProduct[WIDTH-1:0];
      flags_d          = '0;
      flags_d[FLAG_N]  = mulProduct[WIDTH-1];
      flags_d[FLAG_Z]  = (mulProduct[WIDTH-1:0] == '0);
      flags_d[FLAG_C]  = |mulProduct[2*WIDTH-1:WIDTH];
    end
  end

  // Output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
//-----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at WIDTH=8. Each request pushes its
// expected result/flags/latency onto a scoreboard queue; the entry is popped
// and compared when out_valid appears.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic         out_valid, out_ready;
  logic [3:0]   flags;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference model using plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ux, uy, sx, sy, t;
    logic c, v;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    c = 1'b0; v = 1'b0; e.lat = 1; e.res = 8'h00;
    case (o)
      3'b000: begin t = ux + uy; e.res = t[7:0]; c = (t > 255); v = ((sx + sy) > 127) || ((sx + sy) < -128); end
      3'b001: begin t = ux - uy; e.res = t[7:0]; c = (ux >= uy); v = ((sx - sy) > 127) || ((sx - sy) < -128); end
      3'b010: e.res = x & y;
      3'b011: e.res = x | y;
      3'b100: e.res = x ^ y;
      3'b101: begin t = ux * uy; e.res = t[7:0]; c = (t > 255); e.lat = 9; end
      3'b110: begin
        if (ux < 128) e.res = x;
        else begin t = (256 - ux) & 127; e.res = 8'h80 | t[7:0]; v = (ux == 128); end
      end
      default: e.res = 8'h00;
    endcase
    e.flg = {e.res[7], (e.res == 8'h00), c, v};
    return e;
  endfunction

  // Drive a request, hold it until accepted, then scramble the inputs so any
  // late sampling by the DUT would show up as a wrong result.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    expQ.push_back(model(o, x, y));
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 3'b111; a = ~x; b = ~y;
  endtask

  // Wait (bounded) for out_valid; lat = 999 marks a timeout.
  task automatic checkOutput(output logic [7:0] r, output logic [3:0] f, output int lat, output logic sawReady);
    lat = 999; sawReady = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
      if (in_ready) sawReady = 1'b1;
    end
    r = result; f = flags;
  endtask

  task automatic releaseOut;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = '0; b = '0;
    #12;
    testsRun++;
    if ({out_valid, in_ready, result, flags} !== {1'b0, 1'b1, 8'h00, 4'h0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state got v=%b r=%b res=%h f=%b want v=0 r=1 res=00 f=0000", out_valid, in_ready, result, flags);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({out_valid, in_ready} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL post_reset got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  // Runs a list of operations through the scoreboard with inline checks.
  task automatic test_ops(input string name, input logic [2:0] ops[], input logic [7:0] xs[], input logic [7:0] ys[]);
    logic [7:0] r; logic [3:0] f; int lat; logic sr; exp_t e;
    foreach (ops[i]) begin
      applyStimulus(ops[i], xs[i], ys[i]);
      checkOutput(r, f, lat, sr);
      e = expQ.pop_front();
      testsRun++;
      if (r !== e.res) begin testsFailed++; $display("[TB] FAIL %s_result[%0d] op=%0d a=%h b=%h got %h want %h", name, i, ops[i], xs[i], ys[i], r, e.res); end
      testsRun++;
      if (f !== e.flg) begin testsFailed++; $display("[TB] FAIL %s_flags[%0d] op=%0d a=%h b=%h got %b want %b", name, i, ops[i], xs[i], ys[i], f, e.flg); end
      testsRun++;
      if (lat !== e.lat) begin testsFailed++; $display("[TB] FAIL %s_latency[%0d] got %0d want %0d", name, i, lat, e.lat); end
      if (ops[i] == OP_MUL) begin
        testsRun++;
        if (sr !== 1'b0) begin testsFailed++; $display("[TB] FAIL %s_ready_during_mul[%0d] got %b want 0", name, i, sr); end
      end
      releaseOut();
    end
  endtask

  task automatic test_add;
    test_ops("add", '{OP_ADD, OP_ADD, OP_ADD, OP_ADD}, '{8'h7F, 8'hFF, 8'h80, 8'h12}, '{8'h01, 8'h01, 8'h80, 8'h34});
  endtask

  task automatic test_sub;
    test_ops("sub", '{OP_SUB, OP_SUB, OP_SUB, OP_SUB}, '{8'h05, 8'h00, 8'h80, 8'h7F}, '{8'h05, 8'h01, 8'h01, 8'hFF});
  endtask

  task automatic test_logic;
    test_ops("logic", '{OP_AND, OP_OR, OP_XOR, OP_XOR, OP_RSVD}, '{8'hF0, 8'h0F, 8'hAA, 8'h5A, 8'hC3}, '{8'h3C, 8'h30, 8'h55, 8'h5A, 8'h77});
  endtask

  task automatic test_mul;
    test_ops("mul", '{OP_MUL, OP_MUL, OP_MUL, OP_MUL}, '{8'h10, 8'hFF, 8'h03, 8'h00}, '{8'h20, 8'hFF, 8'h05, 8'hAB});
  endtask

  task automatic test_smag;
    test_ops("smag", '{OP_SMAG, OP_SMAG, OP_SMAG, OP_SMAG, OP_SMAG}, '{8'hFB, 8'h80, 8'h05, 8'h00, 8'hFF}, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
  endtask

  // Hold an ADD result under backpressure while a second request waits.
  task automatic test_backpressure;
    logic [7:0] r; logic [3:0] f; int lat; logic sr; exp_t e;
    applyStimulus(OP_ADD, 8'h7F, 8'h01);
    checkOutput(r, f, lat, sr);
    e = expQ.pop_front();
    testsRun++;
    if ({r, f} !== {e.res, e.flg}) begin testsFailed++; $display("[TB] FAIL bp_first got %h/%b want %h/%b", r, f, e.res, e.flg); end
    in_valid = 1'b1; op = OP_OR; a = 8'h0F; b = 8'hF0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      testsRun++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, e.res, e.flg}) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold[%0d] got v=%b r=%b %h/%b want v=1 r=0 %h/%b", k, out_valid, in_ready, result, flags, e.res, e.flg);
      end
    end
    releaseOut();
    applyStimulus(OP_OR, 8'h0F, 8'hF0);
    checkOutput(r, f, lat, sr);
    e = expQ.pop_front();
    testsRun++;
    if ({r, f, lat} !== {e.res, e.flg, e.lat}) begin testsFailed++; $display("[TB] FAIL bp_second got %h/%b lat %0d want %h/%b lat %0d", r, f, lat, e.res, e.flg, e.lat); end
    releaseOut();
  endtask

  // Reset during cycle 4 of a multiply; nothing may come out afterwards.
  task automatic test_reset_mid_mul;
    logic sawOut;
    applyStimulus(OP_MUL, 8'h0F, 8'h0F);
    void'(expQ.pop_back());
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if ({out_valid, in_ready, result, flags} !== {1'b0, 1'b1, 8'h00, 4'h0}) begin
      testsFailed++;
      $display("[TB] FAIL mid_mul_reset got v=%b r=%b %h/%b want v=0 r=1 00/0000", out_valid, in_ready, result, flags);
    end
    @(negedge clk); reset = 1'b0;
    sawOut = 1'b0;
    repeat (15) begin @(negedge clk); if (out_valid) sawOut = 1'b1; end
    testsRun++;
    if ({sawOut, in_ready} !== 2'b01) begin testsFailed++; $display("[TB] FAIL mid_mul_no_stale got out=%b r=%b want out=0 r=1", sawOut, in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops[]; logic [7:0] xs[], ys[];
    ops = new[20]; xs = new[20]; ys = new[20];
    foreach (ops[i]) begin
      ops[i] = 3'($urandom_range(0, 7));
      xs[i]  = 8'($urandom_range(0, 255));
      ys[i]  = 8'($urandom_range(0, 255));
    end
    test_ops("b2b", ops, xs, ys);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_smag();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired after %0d tests", testsRun);
    $fatal(1, "[TB] watchdog");
  end

endmodule
